// File: rtl/alu_rec_pkg.sv
// Shared definitions for the ALU vector recorder: record layout, FSM encoding and record packing.
// The record format matches the 108-bit vectors consumed by the ALU test bench.
package alu_rec_pkg;

  localparam int unsigned REC_W  = 108;
  localparam int unsigned OP_MSB = 107;
  localparam int unsigned FN_MSB = 101;
  localparam int unsigned A_MSB  = 95;
  localparam int unsigned B_MSB  = 63;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    FROZEN  = 2'd2
  } rec_state_e;

  function automatic logic [REC_W-1:0] pack_record(input logic [5:0]  op,
                                                   input logic [5:0]  fn,
                                                   input logic [31:0] a,
                                                   input logic [31:0] b,
                                                   input logic [31:0] res);
    logic [REC_W-1:0] rec;
    rec                = '0;
    rec[OP_MSB -: 6]   = op;
    rec[FN_MSB -: 6]   = fn;
    rec[A_MSB -: 32]   = a;
    rec[B_MSB -: 32]   = b;
    rec[31:0]          = res;
    return rec;
  endfunction

endpackage

// File: rtl/alu_rec_store.sv
// Circular record store: DEPTH x REC_W register array, wrapping pointers and occupancy count.
// A write while full overwrites the oldest entry by advancing the read pointer as well.
module alu_rec_store
  import alu_rec_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr,
  input  logic                       i_rd,
  input  logic [REC_W-1:0]           i_data,
  output logic [REC_W-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH+1);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [PTRW-1:0]  r_wptr;
  logic [PTRW-1:0]  r_rptr;
  logic [CNTW-1:0]  r_count;

  logic w_rd;
  logic w_rd_adv;

  assign o_full   = (r_count == CNTW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rptr];
  assign w_rd     = i_rd & ~o_empty;
  // Overwrite on full drops the oldest record; a concurrent read still advances only once.
  assign w_rd_adv = w_rd | (i_wr & o_full);

  always_ff @(posedge i_clk) begin
    if (i_wr) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr) begin
        r_wptr <= r_wptr + PTRW'(1);
      end
      if (w_rd_adv) begin
        r_rptr <= r_rptr + PTRW'(1);
      end
      unique case ({i_wr, w_rd_adv})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_vector_recorder.sv
// ALU vector recorder top: capture FSM, record packing and saturating drop counter.
// Define ALU_REC_WRAP_EN to overwrite the oldest record when full instead of freezing.
module alu_vector_recorder
  import alu_rec_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned DROPW = 16
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       Arm,
  input  logic                       Stop,
  input  logic                       InValid,
  input  logic [5:0]                 Opcode,
  input  logic [5:0]                 Funct,
  input  logic [31:0]                A,
  input  logic [31:0]                B,
  input  logic [31:0]                Result,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [REC_W-1:0]           OutRecord,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty,
  output logic                       Capturing,
  output logic [DROPW-1:0]           DropCount
);

  localparam int unsigned CNTW = $clog2(DEPTH+1);

  rec_state_e       r_state;
  rec_state_e       w_state_d;
  logic [DROPW-1:0] r_drop;
  logic             w_wr;
  logic             w_rd;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;

  assign w_rec     = pack_record(Opcode, Funct, A, B, Result);
  assign OutValid  = ~Empty;
  assign w_rd      = OutValid & OutReady;
  assign Capturing = (r_state == CAPTURE);
  assign DropCount = r_drop;

`ifdef ALU_REC_WRAP_EN
  assign w_wr   = Capturing & InValid;
  assign w_drop = w_wr & Full;
`else
  assign w_wr   = Capturing & InValid & ~Full;
  assign w_drop = (r_state == FROZEN) & InValid;
`endif

  alu_rec_store #(
    .DEPTH (DEPTH)
  ) u_store (
    .i_clk   (Clock),
    .i_rst_n (Reset_n),
    .i_wr    (w_wr),
    .i_rd    (w_rd),
    .i_data  (w_rec),
    .o_data  (OutRecord),
    .o_count (Count),
    .o_full  (Full),
    .o_empty (Empty)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE: begin
        if (Arm) w_state_d = CAPTURE;
      end
      CAPTURE: begin
        if (Stop) begin
          w_state_d = IDLE;
`ifndef ALU_REC_WRAP_EN
        end else if (w_wr && !w_rd && (Count == CNTW'(DEPTH - 1))) begin
          w_state_d = FROZEN;
`endif
        end
      end
      FROZEN: begin
        if (w_rd && (Count == CNTW'(1))) w_state_d = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_drop && (r_drop != {DROPW{1'b1}})) begin
        r_drop <= r_drop + DROPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_vector_recorder.sv
// Scoreboard bench for alu_vector_recorder: stimulus pushes expected records, a negedge monitor
// pops and compares on every handshake. Define ALU_REC_WRAP_EN to exercise the overwrite mode.
module tb_alu_vector_recorder;
  import alu_rec_pkg::*;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DROPW = 16;

  logic                       Clock = 1'b0;
  logic                       Reset_n;
  logic                       Arm, Stop, InValid, OutReady;
  logic [5:0]                 Opcode, Funct;
  logic [31:0]                A, B, Result;
  logic                       OutValid;
  logic [REC_W-1:0]           OutRecord;
  logic [$clog2(DEPTH+1)-1:0] Count;
  logic                       Full, Empty, Capturing;
  logic [DROPW-1:0]           DropCount;

  alu_vector_recorder #(
    .DEPTH (DEPTH),
    .DROPW (DROPW)
  ) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Arm       (Arm),
    .Stop      (Stop),
    .InValid   (InValid),
    .Opcode    (Opcode),
    .Funct     (Funct),
    .A         (A),
    .B         (B),
    .Result    (Result),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .OutRecord (OutRecord),
    .Count     (Count),
    .Full      (Full),
    .Empty     (Empty),
    .Capturing (Capturing),
    .DropCount (DropCount)
  );

  always #5 Clock = ~Clock;

  int               n_vec  = 0;
  int               n_fail = 0;
  int               next_id = 0;
  logic [REC_W-1:0] sb_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted record must match the oldest expected one.
  always @(negedge Clock) begin
    if (Reset_n === 1'b1 && OutValid === 1'b1 && OutReady === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL sb_underflow: got record %0h, expected none", OutRecord);
      end else begin
        check("record", 128'(OutRecord), 128'(sb_q.pop_front()));
      end
    end
  end

  function automatic logic [REC_W-1:0] rec_of(input int id);
    logic [5:0]  op, fn;
    logic [31:0] a, b;
    op = 6'(id);
    fn = 6'(id * 5 + 1);
    a  = 32'h1000_0000 + 32'(id);
    b  = 32'hCAFE_0000 ^ 32'(id);
    return {op, fn, a, b, a + b};
  endfunction

  task automatic drive(input bit arm, input bit stop, input bit inv, input bit rdy,
                       input logic [REC_W-1:0] r, input bit exp_wr);
    Arm = arm; Stop = stop; InValid = inv; OutReady = rdy;
    {Opcode, Funct, A, B, Result} = r;
    if (exp_wr) sb_q.push_back(r);
    @(posedge Clock);
    #1;
    Arm = 1'b0; Stop = 1'b0; InValid = 1'b0; OutReady = 1'b0;
  endtask

  task automatic wr_next(input bit rdy, input bit exp_wr);
    drive(1'b0, 1'b0, 1'b1, rdy, rec_of(next_id), exp_wr);
    next_id++;
  endtask

  task automatic idle_cycle(input bit arm, input bit stop, input bit rdy);
    drive(arm, stop, 1'b0, rdy, '0, 1'b0);
  endtask

  logic [REC_W-1:0] exp_rec;

  initial begin
    Reset_n = 1'b0; Arm = 1'b0; Stop = 1'b0; InValid = 1'b0; OutReady = 1'b0;
    {Opcode, Funct, A, B, Result} = '0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;

    check("rst_count", 128'(Count), 0);
    check("rst_outvalid", 128'(OutValid), 0);
    check("rst_empty", 128'(Empty), 1);
    check("rst_full", 128'(Full), 0);
    check("rst_capturing", 128'(Capturing), 0);
    check("rst_dropcount", 128'(DropCount), 0);

    // InValid in IDLE is neither stored nor counted as a drop.
    wr_next(1'b0, 1'b0);
    check("idle_count", 128'(Count), 0);
    check("idle_drop", 128'(DropCount), 0);

    // Scenario 1: three captured ops, first one is 5 + 3 = 8.
    idle_cycle(1'b1, 1'b0, 1'b0);
    check("arm_capturing", 128'(Capturing), 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, {6'b000000, 6'b100001, 32'h5, 32'h3, 32'h8}, 1'b1);
    check("first_latency_valid", 128'(OutValid), 1);
    wr_next(1'b0, 1'b1);
    wr_next(1'b0, 1'b1);
    check("s1_count", 128'(Count), 3);
    exp_rec = 108'h021_00000005_00000003_00000008;
    check("s1_first_record", 128'(OutRecord), 128'(exp_rec));
    idle_cycle(1'b0, 1'b1, 1'b0);
    check("stop_capturing", 128'(Capturing), 0);
    repeat (3) idle_cycle(1'b0, 1'b0, 1'b1);
    check("s1_drained_empty", 128'(Empty), 1);

`ifndef ALU_REC_WRAP_EN
    // Scenario 2: fill to DEPTH, freeze, then five drops.
    idle_cycle(1'b1, 1'b0, 1'b0);
    repeat (DEPTH) wr_next(1'b0, 1'b1);
    check("s2_full", 128'(Full), 1);
    check("s2_state_frozen", 128'(dut.r_state), 128'(FROZEN));
    check("s2_capturing", 128'(Capturing), 0);
    idle_cycle(1'b1, 1'b0, 1'b0);
    check("s2_arm_ignored", 128'(dut.r_state), 128'(FROZEN));
    repeat (5) wr_next(1'b0, 1'b0);
    check("s2_dropcount", 128'(DropCount), 5);
    check("s2_count", 128'(Count), DEPTH);

    // Scenario 3: drain everything; last transfer returns to IDLE.
    repeat (DEPTH) idle_cycle(1'b0, 1'b0, 1'b1);
    check("s3_empty", 128'(Empty), 1);
    check("s3_state_idle", 128'(dut.r_state), 128'(IDLE));
`endif

    // Move both pointers near the top so scenario 4 wraps past index DEPTH-1.
    idle_cycle(1'b1, 1'b0, 1'b0);
    repeat (24) wr_next(1'b0, 1'b1);
    idle_cycle(1'b0, 1'b1, 1'b0);
    repeat (24) idle_cycle(1'b0, 1'b0, 1'b1);
    check("fill_empty", 128'(Empty), 1);

    // Scenario 4: steady state with simultaneous write and transfer.
    idle_cycle(1'b1, 1'b0, 1'b0);
    repeat (4) wr_next(1'b0, 1'b1);
    check("s4_count_start", 128'(Count), 4);
    for (int i = 0; i < 10; i++) begin
      wr_next(1'b1, 1'b1);
      check("s4_count_steady", 128'(Count), 4);
    end

    // Scenario 5: reset mid-capture with Count = 7 and a live handshake.
    repeat (3) wr_next(1'b0, 1'b1);
    check("s5_count_pre", 128'(Count), 7);
    Reset_n = 1'b0; InValid = 1'b1; OutReady = 1'b1;
    {Opcode, Funct, A, B, Result} = rec_of(next_id);
    @(posedge Clock);
    #1;
    Reset_n = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    sb_q.delete();
    check("s5_count", 128'(Count), 0);
    check("s5_outvalid", 128'(OutValid), 0);
    check("s5_state_idle", 128'(dut.r_state), 128'(IDLE));
    check("s5_dropcount", 128'(DropCount), 0);

`ifdef ALU_REC_WRAP_EN
    // Scenario 6: 34 writes into 32 slots overwrite the two oldest.
    idle_cycle(1'b1, 1'b0, 1'b0);
    exp_rec = rec_of(next_id + 2);
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (sb_q.size() == DEPTH) void'(sb_q.pop_front());
      wr_next(1'b0, 1'b1);
    end
    check("s6_count", 128'(Count), DEPTH);
    check("s6_full", 128'(Full), 1);
    check("s6_capturing", 128'(Capturing), 1);
    check("s6_first_record", 128'(OutRecord), 128'(exp_rec));
    check("s6_dropcount", 128'(DropCount), 2);
    idle_cycle(1'b0, 1'b1, 1'b0);
    repeat (DEPTH) idle_cycle(1'b0, 1'b0, 1'b1);
    check("s6_empty", 128'(Empty), 1);
`endif

    check("sb_leftover", 128'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_vector_recorder.md
Name: alu_vector_recorder

Overview:
- Hardware writer for ALU test vectors; the producer side of the 108-bit vector format that the ALU test bench consumes.
- Snoops the ALUdec/ALU boundary in the MIPS150 datapath and packs each valid operation into one record: opcode, funct, A, B, result.
- Buffers records in a circular store and drains them over a valid/ready port. Dumped records can be reloaded as test vectors with $readmemb.

Parameters:
- DEPTH, 32, number of records stored; power of two, at least 2.
- DROPW, 16, width of the saturating drop counter.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of Clock.
- Arm  input  1  one-cycle request to start capturing.
- Stop  input  1  one-cycle request to stop capturing.
- InValid  input  1  the ALU operation on the inputs this cycle is to be recorded.
- Opcode  input  6  instruction opcode.
- Funct  input  6  instruction funct field.
- A  input  32  ALU operand A.
- B  input  32  ALU operand B.
- Result  input  32  ALU output.
- OutValid  output  1  OutRecord holds the oldest stored record.
- OutReady  input  1  consumer accepts OutRecord.
- OutRecord  output  108  record layout: [107:102] opcode, [101:96] funct, [95:64] A, [63:32] B, [31:0] result.
- Count  output  $clog2(DEPTH+1)  number of records stored.
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.
- Capturing  output  1  FSM is in CAPTURE.
- DropCount  output  DROPW  InValid cycles rejected while FROZEN; saturating.

Behaviour:
- Reset (Reset_n = 0 at a rising edge):
  - FSM goes to IDLE; read pointer, write pointer, Count and DropCount clear to 0.
  - Outputs after reset: OutValid = 0, Empty = 1, Full = 0, Capturing = 0, DropCount = 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all records, including a read being handshaked in the same cycle.
- Storage: DEPTH x 108 register array. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write: in CAPTURE with InValid = 1 and not Full, the packed record is written at the write pointer and the write pointer increments.
- Read: first-word-fall-through.
  - OutValid = !Empty; OutRecord = mem[read pointer], combinational from the array.
  - A transfer occurs when OutValid and OutReady are both 1; the read pointer then increments.
  - OutReady while Empty has no effect.
- Latency: a record written at edge t shows OutValid = 1 in the cycle after edge t.
- Count: +1 on a write, -1 on a transfer, unchanged on a simultaneous write and transfer.
- FSM:
  - IDLE: Arm -> CAPTURE. InValid is ignored and not counted as a drop.
  - CAPTURE:
    - Stop -> IDLE; the operation in the same cycle is still written if InValid = 1.
    - A write that makes Count reach DEPTH, with no simultaneous read, -> FROZEN on the same edge.
    - Arm has no effect.
  - FROZEN:
    - No writes. Each InValid cycle increments DropCount, saturating at all-ones.
    - Reads continue; when Count returns to 0 (the last transfer) -> IDLE.
    - Arm and Stop are ignored.
  - Arm and Stop asserted together: Stop wins in CAPTURE; Arm wins in IDLE.
- Full plus simultaneous write and read in CAPTURE: cannot occur without the optional feature, because a full buffer forces FROZEN.
- DropCount clears only on reset.

Optional Feature:
- Macro: ALU_REC_WRAP_EN.
- Defined:
  - FROZEN is never entered; CAPTURE continues when Full.
  - A write while Full overwrites the oldest record: both pointers increment and Count stays at DEPTH.
  - If a consumer transfer happens in the same cycle, the read pointer still increments only once.
  - Each overwrite increments DropCount, saturating.
- Not defined: behaviour as specified in Behaviour (freeze on full).

Decomposition:
- Shared package alu_rec_pkg holds:
  - record field offsets (OP_MSB = 107, FN_MSB = 101, A_MSB = 95, B_MSB = 63) and REC_W = 108;
  - FSM state encoding: IDLE = 2'd0, CAPTURE = 2'd1, FROZEN = 2'd2.
- One sub-module, alu_rec_store: DEPTH x REC_W register array with pointers and count. The top holds the FSM, record packing and the drop counter.

Test Plan:
1. Reset, Arm, then 3 InValid ops with OutReady = 0; one is op 000000, fn 100001, A = 0x00000005, B = 0x00000003, Result = 0x00000008 -> Count = 3, and the first OutRecord equals {6'b000000, 6'b100001, 0x5, 0x3, 0x8}.
2. Arm, then 32 consecutive writes with OutReady = 0 -> Full = 1, FSM is FROZEN, Capturing = 0; 5 more InValid -> DropCount = 5 and Count stays 32.
3. From scenario 2, hold OutReady = 1 for 32 cycles -> records come out in write order; Empty = 1; FSM returns to IDLE.
4. CAPTURE with Count = 4, simultaneous InValid and transfer for 10 cycles -> Count stays 4 and order is preserved; the read pointer wraps correctly past index 31 to 0.
5. Reset_n = 0 in mid-capture with Count = 7 and a handshake active -> the next cycle shows Count = 0, OutValid = 0, FSM IDLE, DropCount = 0.
6. With ALU_REC_WRAP_EN defined: write 34 records with no reads -> Count = 32, the first OutRecord is record #3, DropCount = 2.
